// File: rtl/conv_window_sched_pkg.sv
// Shared types and sizing helpers for the 3x3 convolution window scheduler.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    localparam int DW_DEFAULT = 8;

    // Counter/address width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// Pixel-stream, core-facing and status signals of the window scheduler.
interface conv_window_sched_if #(
    parameter int DW = conv_pkg::DW_DEFAULT
);
    logic          start;
    logic          pix_valid_i;
    logic [DW-1:0] pix_i;
    logic          pix_ready_o;
    logic [DW-1:0] fifo1_data_o;
    logic [DW-1:0] fifo2_data_o;
    logic [DW-1:0] fifo3_data_o;
    logic          conv_ready_o;
    logic          conv_done_i;
    logic          busy_o;
    logic          frame_done_o;

    modport slave (
        input  start, pix_valid_i, pix_i, conv_done_i,
        output pix_ready_o, fifo1_data_o, fifo2_data_o, fifo3_data_o,
               conv_ready_o, busy_o, frame_done_o
    );

    modport master (
        output start, pix_valid_i, pix_i, conv_done_i,
        input  pix_ready_o, fifo1_data_o, fifo2_data_o, fifo3_data_o,
               conv_ready_o, busy_o, frame_done_o
    );
endinterface

// File: rtl/conv_window_sched_line_buf.sv
// One image-row line buffer: asynchronous read, synchronous write, so a read
// and a write to the same address in one cycle returns the old contents.
module line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [cnt_w(DEPTH)-1:0] addr,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Buffers the two previous rows of a raster pixel stream and emits vertically
// aligned column triples to the 3x3 convolution core.
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_window_sched_if.slave  bus
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    sched_state_t state_reg, state_next;
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic          accept;
    logic          last_col;
    logic          last_row;

    logic [DW-1:0] lb_wdata [2];
    logic [DW-1:0] lb_rdata [2];

    logic [DW-1:0] fifo1_reg, fifo2_reg, fifo3_reg;
    logic          conv_ready_reg;

    assign accept   = bus.pix_valid_i && bus.pix_ready_o;
    assign last_col = (col_reg == CW'(IMG_W - 1));
    assign last_row = (row_reg == RW'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bus.pix_ready_o  = 1'b0;
        bus.busy_o       = 1'b1;
        bus.frame_done_o = 1'b0;
        case (state_reg)
            S_IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.start) state_next = S_PRIME;
            end
            S_PRIME: begin
                bus.pix_ready_o = 1'b1;
                if (accept && last_col && row_reg == RW'(1)) state_next = S_RUN;
            end
            S_RUN: begin
                bus.pix_ready_o = 1'b1;
                if (accept && last_col && last_row) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.conv_done_i) state_next = S_DONE;
            end
            S_DONE: begin
                bus.frame_done_o = 1'b1;
                state_next       = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters restart only from IDLE; a start pulse mid-frame must not disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (state_reg == S_IDLE && bus.start) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_reg <= '0;
                row_reg <= last_row ? '0 : row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // LB0 holds row r-1 and shifts its old contents into LB1 (row r-2).
    assign lb_wdata[0] = bus.pix_i;
    assign lb_wdata[1] = lb_rdata[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
        line_buf #(
            .DEPTH (IMG_W),
            .DW    (DW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col_reg),
            .wdata (lb_wdata[gi]),
            .rdata (lb_rdata[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo1_reg      <= '0;
            fifo2_reg      <= '0;
            fifo3_reg      <= '0;
            conv_ready_reg <= 1'b0;
        end else if (accept && state_reg == S_RUN) begin
            fifo1_reg      <= lb_rdata[1];
            fifo2_reg      <= lb_rdata[0];
            fifo3_reg      <= bus.pix_i;
            conv_ready_reg <= 1'b1;
        end else begin
            conv_ready_reg <= 1'b0;
        end
    end

    assign bus.fifo1_data_o = fifo1_reg;
    assign bus.fifo2_data_o = fifo2_reg;
    assign bus.fifo3_data_o = fifo3_reg;
    assign bus.conv_ready_o = conv_ready_reg;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on a 4x4 frame: triples, gaps, restarts,
// mid-frame reset, row/column pattern and DRAIN wait.
module tb_conv_window_sched;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [7:0] last1 = '0, last2 = '0, last3 = '0;

    conv_window_sched_if #(.DW(8)) bus ();

    conv_window_sched #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int base, input bit wrap, input int i);
        if (wrap) return 8'((i / W) + (i % W));
        return 8'(base + i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", bus.busy_o, 1);
        chk("start_pix_ready", bus.pix_ready_o, 1);
        chk("start_frame_done", bus.frame_done_o, 0);
    endtask

    // Sends pixels 0..n-1 of a frame, checking every registered triple and held outputs.
    task automatic feed(input int base, input bit wrap, input bit gaps, input int n,
                        input logic [15:0] restart_mask);
        for (int i = 0; i < n; i++) begin
            bus.pix_valid_i = 1'b1;
            bus.pix_i       = pv(base, wrap, i);
            bus.start       = restart_mask[i];
            step();
            bus.pix_valid_i = 1'b0;
            bus.start       = 1'b0;
            if (i / W >= 2) begin
                last1 = pv(base, wrap, i - 2 * W);
                last2 = pv(base, wrap, i - W);
                last3 = pv(base, wrap, i);
                strobes++;
                $display("triple %0d: %0d %0d %0d", strobes, bus.fifo1_data_o,
                         bus.fifo2_data_o, bus.fifo3_data_o);
            end
            chk("conv_ready", bus.conv_ready_o, (i / W >= 2) ? 1 : 0);
            chk("fifo1", bus.fifo1_data_o, last1);
            chk("fifo2", bus.fifo2_data_o, last2);
            chk("fifo3", bus.fifo3_data_o, last3);
            chk("pix_ready_after_beat", bus.pix_ready_o, (i == W * H - 1) ? 0 : 1);
            if (gaps) begin
                step();
                chk("gap_conv_ready", bus.conv_ready_o, 0);
                chk("gap_fifo1", bus.fifo1_data_o, last1);
                chk("gap_fifo2", bus.fifo2_data_o, last2);
                chk("gap_fifo3", bus.fifo3_data_o, last3);
            end
        end
    endtask

    // Waits in DRAIN for a number of cycles (offering a stray pixel), then finishes.
    task automatic end_frame(input int wait_cycles);
        int pulses = 0;
        for (int k = 0; k < wait_cycles; k++) begin
            bus.pix_valid_i = 1'b1;
            bus.pix_i       = 8'hEE;
            step();
            chk("drain_pix_ready", bus.pix_ready_o, 0);
            chk("drain_busy", bus.busy_o, 1);
            chk("drain_frame_done", bus.frame_done_o, 0);
            chk("drain_conv_ready", bus.conv_ready_o, 0);
        end
        bus.pix_valid_i = 1'b0;
        bus.conv_done_i = 1'b1;
        step();
        bus.conv_done_i = 1'b0;
        chk("done_frame_done", bus.frame_done_o, 1);
        chk("done_busy", bus.busy_o, 1);
        pulses += bus.frame_done_o ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            step();
            pulses += bus.frame_done_o ? 1 : 0;
        end
        chk("frame_done_pulses", pulses, 1);
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_pix_ready", bus.pix_ready_o, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready_o, 0);
        chk({tag, "_conv_ready"}, bus.conv_ready_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_frame_done"}, bus.frame_done_o, 0);
        chk({tag, "_fifo1"}, bus.fifo1_data_o, 0);
        chk({tag, "_fifo2"}, bus.fifo2_data_o, 0);
        chk({tag, "_fifo3"}, bus.fifo3_data_o, 0);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.pix_valid_i = 1'b0;
        bus.pix_i       = '0;
        bus.conv_done_i = 1'b0;

        // Reset state
        step();
        step();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        step();
        bus.pix_valid_i = 1'b1;
        step();
        chk("idle_no_accept", bus.pix_ready_o, 0);
        chk("idle_no_strobe", bus.conv_ready_o, 0);
        bus.pix_valid_i = 1'b0;

        // Basic back-to-back frame
        pulse_start();
        strobes = 0;
        feed(0, 1'b0, 1'b0, W * H, 16'h0000);
        chk("basic_strobes", strobes, 8);
        end_frame(0);

        // Gapped source, DRAIN held for 20 cycles
        pulse_start();
        strobes = 0;
        feed(0, 1'b0, 1'b1, W * H, 16'h0000);
        chk("gap_strobes", strobes, 8);
        end_frame(20);

        // Restart pulses in PRIME and RUN; conv_done already high on DRAIN entry
        pulse_start();
        strobes = 0;
        bus.conv_done_i = 1'b1;
        feed(0, 1'b0, 1'b0, W * H, 16'h0404);
        chk("restart_strobes", strobes, 8);
        end_frame(0);

        // Reset after pixel 9
        pulse_start();
        strobes = 0;
        feed(0, 1'b0, 1'b0, 10, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        step();
        rst_n = 1'b1;
        last1 = '0;
        last2 = '0;
        last3 = '0;
        step();
        pulse_start();
        strobes = 0;
        feed(100, 1'b0, 1'b0, W * H, 16'h0000);
        chk("after_reset_strobes", strobes, 8);
        end_frame(2);

        // Row+column pattern across column wrap
        pulse_start();
        strobes = 0;
        feed(0, 1'b1, 1'b0, W * H, 16'h0000);
        chk("pattern_strobes", strobes, 8);
        chk("pattern_f2_f1", 8'(bus.fifo2_data_o - bus.fifo1_data_o), 1);
        chk("pattern_f3_f1", 8'(bus.fifo3_data_o - bus.fifo1_data_o), 2);
        end_frame(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Scheduler that sequences the 3x3 convolution core. It accepts a raster-order pixel stream for one frame and buffers the two previous image rows. Once a third row arrives, it presents vertically aligned column triples on the core's three row inputs (`fifo1/2/3`), strobing `ready` for each one. It sits between the frame source and the convolution core, and reports frame start, busy and completion to the stitching top level.

## Interface

Parameters:
- `IMG_W`, default 640: pixels per row; must be ≥ 3.
- `IMG_H`, default 480: rows per frame; must be ≥ 3.
- `DW`, default 8: pixel width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- `pix_valid_i`  in  1  source pixel valid.
- `pix_i`  in  DW  source pixel, raster order.
- `pix_ready_o`  out  1  scheduler can accept a pixel; a beat transfers when `pix_valid_i && pix_ready_o`.
- `fifo1_data_o`  out  DW  pixel from row r-2 (oldest).
- `fifo2_data_o`  out  DW  pixel from row r-1.
- `fifo3_data_o`  out  DW  pixel from row r (current).
- `conv_ready_o`  out  1  column-triple strobe to the core's `ready`.
- `conv_done_i`  in  1  core `done_o`; clears the DRAIN wait.
- `busy_o`  out  1  high in any state other than IDLE.
- `frame_done_o`  out  1  one-cycle pulse at frame completion.

## Operation

**States.** IDLE, PRIME, RUN, DRAIN, DONE.

**Transitions.**
- IDLE → PRIME on `start`.
- PRIME → RUN after accepting pixel (row 1, col IMG_W-1).
- RUN → DRAIN after accepting pixel (IMG_H-1, IMG_W-1).
- DRAIN → DONE on `conv_done_i`.
- DONE → IDLE unconditionally, after one cycle.

**Handshake.**
- `pix_ready_o` = 1 only in PRIME and RUN.
- Pixels offered in IDLE, DRAIN or DONE are not accepted.

**Counters.**
- `col` is $clog2(IMG_W) bits and wraps IMG_W-1 → 0.
- `row` is $clog2(IMG_H) bits and increments on each col wrap.
- Both counters advance only on accepted beats.
- Both are cleared on `start`.

**Line buffers.**
- Two circular buffers, LB0 (row r-1) and LB1 (row r-2), each IMG_W×DW, addressed by `col`.
- On each accepted beat, both buffers are read at `col` before being written (read-before-write).
- LB1 is written with the value read from LB0.
- LB0 is written with `pix_i`.

**Triple emission.**
- Emitted only for beats accepted with row ≥ 2, i.e. in RUN.
- Outputs: `fifo1_data_o` = LB1[col], `fifo2_data_o` = LB0[col], `fifo3_data_o` = `pix_i`.
- No triple is emitted during PRIME.
- Total triples per frame: IMG_W×(IMG_H-2).

**Gaps.** When `pix_valid_i` is low, `conv_ready_o` is 0 and the `fifo*_data_o` outputs hold their last value.

**Reset and restart.**
- `start` while busy is ignored.
- Asserting `rst_n` low mid-frame forces IDLE and clears counters.
- Line-buffer contents need not be cleared; they are fully rewritten in PRIME.

## Timing

**Reset values.**
- `pix_ready_o`, `conv_ready_o`, `busy_o`, `frame_done_o` = 0.
- `fifo1/2/3_data_o` = 0.
- State = IDLE; `col` = `row` = 0.

**Start latency.** `start` at edge N gives `busy_o` = 1 and `pix_ready_o` = 1 from N+1.

**Triple latency.**
- A beat accepted at edge N produces `fifo*_data_o` and `conv_ready_o` = 1 registered at N+1.
- All four outputs change together.
- `conv_ready_o` is high for exactly one cycle per triple.

**End of frame.**
- The last accepted beat drops `pix_ready_o` on the next cycle.
- `frame_done_o` pulses in the DONE cycle.
- `busy_o` falls in the following cycle.

**Boundary cases.**
- If `conv_done_i` is already high on the DRAIN entry cycle, DRAIN lasts one cycle.
- Throughput: one pixel per cycle sustained, with no bubbles at row boundaries.

## Structure

- Package `conv_pkg`:
  - state enum `sched_state_t`.
  - `DW` default.
  - `localparam` helpers for counter widths.
- Sub-module `line_buf`: a single-port, read-before-write, synchronous-write RAM with asynchronous read, parameterised by `DEPTH` and `DW`. It is instantiated twice.

## Test plan

Scenarios 1–4 use IMG_W=4 and IMG_H=4.

1. **Basic frame.** `start`, then pixels 0..15 back-to-back.
   - Expect 8 `conv_ready_o` strobes.
   - First triple is (0,4,8) one cycle after pixel 8 is accepted; last triple is (7,11,15).
   - `frame_done_o` pulses once after `conv_done_i`.
2. **Source gaps.** Same frame with `pix_valid_i` toggled 1,0,1,0…
   - Same 8 triples in the same order, with `conv_ready_o` only after valid beats.
   - Outputs hold their value during gaps.
3. **Restart attempts.** `start` pulsed during PRIME and during RUN.
   - Counters are not cleared.
   - Exactly one `frame_done_o`, and the triple sequence is unchanged.
4. **Reset mid-frame.** `rst_n` low after pixel 9.
   - All outputs return to 0 and state returns to IDLE.
   - A new `start` with pixels 100..115 yields first triple (100,104,108).
5. **Wrap-around.** IMG_W=640, IMG_H=480 with pixel = (row+col) mod 256.
   - 640×478 strobes.
   - Every triple satisfies f2 = f1+1 and f3 = f1+2 (mod 256); no discontinuity at col 639→0.
6. **DRAIN wait.** Hold `conv_done_i` low for 20 cycles after the last pixel.
   - DRAIN persists, `pix_ready_o` = 0 and `busy_o` = 1.
   - `frame_done_o` fires one cycle after `conv_done_i` rises.
